// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data memory (8-bit address,
// 16-bit data, 1-cycle read latency) between the CPU MEM stage and a host
// loader/debug port. The CPU has fixed priority. A host that has been refused
// for WAIT_LIMIT consecutive cycles wins the next arbitration. A locked host
// burst is broken after MAX_BURST grants while the CPU is waiting.
module dmem_arbiter #(
    parameter int WAIT_LIMIT = 4,   // 1..15
    parameter int MAX_BURST  = 8    // 1..15
) (
    input  logic        clock,
    input  logic        reset,
    // CPU channel
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    // Host channel
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_lock,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [15:0] host_rdata,
    // Memory side
    output logic [7:0]  d_addr,
    output logic [15:0] d_dataout,
    output logic        d_we,
    input  logic [15:0] d_datain
);

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CPU  = 2'd1;
    localparam logic [1:0] OWNER_HOST = 2'd2;

    localparam logic [3:0] WAIT_LIM  = 4'(WAIT_LIMIT);
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    localparam logic [3:0] CNT_MAX   = 4'hF;

    logic [1:0] owner_q, owner_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pend_cpu_q, rd_pend_cpu_d;
    logic       rd_pend_host_q, rd_pend_host_d;

    logic lock_hold;
    logic host_starved;
    logic cpu_win;
    logic host_win;

    // Arbitration: locked host, then starved host, then CPU, then host.
    always_comb begin
        // Comparing with >= (not ==) keeps the lock breakable even if the
        // burst counter ran past the limit while the CPU was idle.
        lock_hold    = (owner_q == OWNER_HOST) && host_req && host_lock &&
                       !(cpu_req && (burst_cnt_q >= BURST_LIM));
        host_starved = host_req && (wait_cnt_q >= WAIT_LIM);
        host_win     = !reset && (lock_hold || host_starved || (host_req && !cpu_req));
        cpu_win      = !reset && cpu_req && !lock_hold && !host_starved;
    end

    // Route the winning channel onto the memory pins; idle drives zeros.
    always_comb begin
        d_addr    = '0;
        d_dataout = '0;
        d_we      = 1'b0;
        if (cpu_win) begin
            d_addr    = cpu_addr;
            d_dataout = cpu_wdata;
            d_we      = cpu_we;
        end else if (host_win) begin
            d_addr    = host_addr;
            d_dataout = host_wdata;
            d_we      = host_we;
        end
    end

    assign cpu_gnt     = cpu_win;
    assign host_gnt    = host_win;
    assign cpu_rvalid  = rd_pend_cpu_q && !reset;
    assign host_rvalid = rd_pend_host_q && !reset;
    assign cpu_rdata   = cpu_rvalid  ? d_datain : '0;
    assign host_rdata  = host_rvalid ? d_datain : '0;

    // Next-state for owner, saturating counters and read-return flags.
    always_comb begin
        owner_d = OWNER_NONE;
        if (cpu_win) begin
            owner_d = OWNER_CPU;
        end else if (host_win) begin
            owner_d = OWNER_HOST;
        end

        if (host_win || !host_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if (host_win && host_lock) begin
            burst_cnt_d = (burst_cnt_q != CNT_MAX) ? burst_cnt_q + 4'd1 : burst_cnt_q;
        end else begin
            burst_cnt_d = '0;
        end

        rd_pend_cpu_d  = cpu_win && !cpu_we;
        rd_pend_host_d = host_win && !host_we;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q        <= OWNER_NONE;
            wait_cnt_q     <= '0;
            burst_cnt_q    <= '0;
            rd_pend_cpu_q  <= 1'b0;
            rd_pend_host_q <= 1'b0;
        end else begin
            owner_q        <= owner_d;
            wait_cnt_q     <= wait_cnt_d;
            burst_cnt_q    <= burst_cnt_d;
            rd_pend_cpu_q  <= rd_pend_cpu_d;
            rd_pend_host_q <= rd_pend_host_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for
// dmem_arbiter, checked against a behavioural model of the arbitration rules
// and a shadow copy of the data memory.
module tb_dmem_arbiter;

    localparam int WAIT_LIMIT = 4;
    localparam int MAX_BURST  = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req, host_we, host_lock;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dmem_arbiter #(.WAIT_LIMIT(WAIT_LIMIT), .MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM standing in for the data memory.
    logic [15:0] ram [256];
    always @(posedge clock) begin
        if (d_we) ram[d_addr] <= d_dataout;
        d_datain <= ram[d_addr];
    end

    // ---------------- behavioural reference model ----------------
    // host_owned: host won the previous cycle. refused / lock_run are plain
    // unbounded streak lengths.
    bit          m_host_owned;
    int          m_refused;
    int          m_lock_run;
    bit          m_pc, m_ph;
    logic [15:0] m_pc_data, m_ph_data;
    logic [15:0] smem [256];

    bit          e_cpu, e_host;
    logic [60:0] e_vec;

    function automatic logic [60:0] obs_vec();
        return {cpu_gnt, host_gnt, d_we, d_addr, d_dataout,
                cpu_rvalid, cpu_rdata, host_rvalid, host_rdata};
    endfunction

    task automatic model_eval();
        bit lock, starve;
        logic [7:0] a;
        logic [15:0] wd;
        logic we;
        if (reset) begin
            e_cpu  = 1'b0;
            e_host = 1'b0;
            e_vec  = '0;
        end else begin
            lock   = m_host_owned && host_req && host_lock &&
                     !(cpu_req && (m_lock_run >= MAX_BURST));
            starve = host_req && (m_refused >= WAIT_LIMIT);
            e_host = lock || starve || (host_req && !cpu_req);
            e_cpu  = cpu_req && !e_host;
            a = '0; wd = '0; we = 1'b0;
            if (e_cpu) begin
                a = cpu_addr; wd = cpu_wdata; we = cpu_we;
            end else if (e_host) begin
                a = host_addr; wd = host_wdata; we = host_we;
            end
            e_vec = {e_cpu, e_host, we, a, wd,
                     m_pc, (m_pc ? m_pc_data : 16'h0),
                     m_ph, (m_ph ? m_ph_data : 16'h0)};
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            m_host_owned = 0; m_refused = 0; m_lock_run = 0;
            m_pc = 0; m_ph = 0;
        end else begin
            m_pc = e_cpu && !cpu_we;
            m_ph = e_host && !host_we;
            if (e_cpu)  m_pc_data = smem[cpu_addr];
            if (e_host) m_ph_data = smem[host_addr];
            if (e_cpu && cpu_we)   smem[cpu_addr]  = cpu_wdata;
            if (e_host && host_we) smem[host_addr] = host_wdata;
            if (e_host) begin
                m_refused  = 0;
                m_lock_run = host_lock ? m_lock_run + 1 : 0;
            end else begin
                m_refused  = host_req ? m_refused + 1 : 0;
                m_lock_run = 0;
            end
            m_host_owned = e_host;
        end
    endtask

    task automatic advance();
        @(posedge clock);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        reset = 1; cpu_req = 1; host_req = 1; cpu_addr = 8'h05; host_addr = 8'h06;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); model_eval();
            checks++;
            if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || d_we !== 1'b0 || d_addr !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got gnt=%b%b we=%b addr=%h want 00 0 00",
                         cyc, cpu_gnt, host_gnt, d_we, d_addr);
            end
            checks++;
            if (obs_vec() !== e_vec) begin
                errors++;
                $display("FAIL reset_model cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
            end
            advance();
        end
        reset = 0;
        @(negedge clock); model_eval();
        checks++;
        if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant cyc %0d got cpu=%b host=%b want cpu=1 host=0",
                     cyc, cpu_gnt, host_gnt);
        end
        advance();
        set_idle();
        @(negedge clock); model_eval(); advance();
    endtask

    // Host writes every address so the RAM has defined contents.
    task automatic test_preload();
        set_idle();
        for (int i = 0; i < 256; i++) begin
            host_req = 1; host_we = 1; host_addr = 8'(i); host_wdata = 16'($urandom);
            @(negedge clock); model_eval();
            checks++;
            if (obs_vec() !== e_vec) begin
                errors++;
                $display("FAIL preload cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
            end
            advance();
        end
        set_idle();
    endtask

    task automatic test_cpu_write_read();
        set_idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 16'hA5A5;
        @(negedge clock); model_eval();
        checks++;
        if (cpu_gnt !== 1'b1 || d_we !== 1'b1 || d_addr !== 8'h10 || d_dataout !== 16'hA5A5) begin
            errors++;
            $display("FAIL cpu_write cyc %0d got gnt=%b we=%b addr=%h data=%h want 1 1 10 a5a5",
                     cyc, cpu_gnt, d_we, d_addr, d_dataout);
        end
        advance();
        cpu_we = 0; cpu_wdata = 16'h0;
        @(negedge clock); model_eval();
        checks++;
        if (cpu_gnt !== 1'b1 || d_we !== 1'b0 || d_addr !== 8'h10) begin
            errors++;
            $display("FAIL cpu_read_issue cyc %0d got gnt=%b we=%b addr=%h want 1 0 10",
                     cyc, cpu_gnt, d_we, d_addr);
        end
        advance();
        set_idle();
        @(negedge clock); model_eval();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hA5A5 || host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_return cyc %0d got rvalid=%b rdata=%h want 1 a5a5",
                     cyc, cpu_rvalid, cpu_rdata);
        end
        checks++;
        if (obs_vec() !== e_vec) begin
            errors++;
            $display("FAIL cpu_wr_model cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
        end
        advance();
    endtask

    task automatic test_starvation();
        set_idle();
        @(negedge clock); model_eval(); advance();
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1; host_req = 1; host_lock = 0;
            cpu_addr = 8'($urandom); host_addr = 8'($urandom);
            @(negedge clock); model_eval();
            checks++;
            if (host_gnt !== (i == 4 || i == 9) || cpu_gnt !== !(i == 4 || i == 9)) begin
                errors++;
                $display("FAIL starvation step %0d got cpu=%b host=%b want host=%b",
                         i, cpu_gnt, host_gnt, (i == 4 || i == 9));
            end
            checks++;
            if (obs_vec() !== e_vec) begin
                errors++;
                $display("FAIL starvation_model cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
            end
            advance();
        end
        set_idle();
    endtask

    task automatic test_lock_burst();
        set_idle();
        @(negedge clock); model_eval(); advance();
        for (int i = 0; i < 11; i++) begin
            host_req = 1; host_lock = 1; host_addr = 8'(i);
            cpu_req = (i >= 1 && i <= 8);
            cpu_addr = 8'h80;
            @(negedge clock); model_eval();
            checks++;
            if (host_gnt !== (i != 8) || cpu_gnt !== (i == 8)) begin
                errors++;
                $display("FAIL lock_burst step %0d got cpu=%b host=%b want cpu=%b host=%b",
                         i, cpu_gnt, host_gnt, (i == 8), (i != 8));
            end
            checks++;
            if (obs_vec() !== e_vec) begin
                errors++;
                $display("FAIL lock_model cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
            end
            advance();
        end
        set_idle();
    endtask

    task automatic test_interleaved_reads();
        set_idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 16'h1111;
        @(negedge clock); model_eval(); advance();
        set_idle();
        host_req = 1; host_we = 1; host_addr = 8'h02; host_wdata = 16'h2222;
        @(negedge clock); model_eval(); advance();
        set_idle();
        cpu_req = 1; cpu_addr = 8'h01;
        @(negedge clock); model_eval(); advance();
        set_idle();
        host_req = 1; host_addr = 8'h02;
        @(negedge clock); model_eval();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1111 || host_rvalid !== 1'b0 || host_gnt !== 1'b1) begin
            errors++;
            $display("FAIL interleave_cpu cyc %0d got crv=%b crd=%h hrv=%b hg=%b want 1 1111 0 1",
                     cyc, cpu_rvalid, cpu_rdata, host_rvalid, host_gnt);
        end
        advance();
        set_idle();
        @(negedge clock); model_eval();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== 16'h2222 || cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0) begin
            errors++;
            $display("FAIL interleave_host cyc %0d got hrv=%b hrd=%h crv=%b crd=%h want 1 2222 0 0000",
                     cyc, host_rvalid, host_rdata, cpu_rvalid, cpu_rdata);
        end
        advance();
    endtask

    task automatic test_reset_mid_read();
        set_idle();
        @(negedge clock); model_eval(); advance();
        // Build up a refused streak, then reset while the host requests a read.
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; host_req = 1; host_addr = 8'h33;
            @(negedge clock); model_eval(); advance();
        end
        reset = 1;
        @(negedge clock); model_eval();
        checks++;
        if (host_gnt !== 1'b0 || cpu_gnt !== 1'b0 || host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_gnt cyc %0d got cpu=%b host=%b hrv=%b want 0 0 0",
                     cyc, cpu_gnt, host_gnt, host_rvalid);
        end
        advance();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); model_eval();
            checks++;
            if (host_gnt !== (i == 4) || cpu_gnt !== (i != 4) || (i == 0 && host_rvalid !== 1'b0)) begin
                errors++;
                $display("FAIL reset_counters step %0d got cpu=%b host=%b hrv=%b want host=%b",
                         i, cpu_gnt, host_gnt, host_rvalid, (i == 4));
            end
            advance();
        end
        // A host read in flight when reset rises must not return.
        set_idle();
        host_req = 1; host_addr = 8'h44;
        @(negedge clock); model_eval(); advance();
        set_idle();
        reset = 1;
        @(negedge clock); model_eval();
        checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_inflight cyc %0d got hrv=%b hrd=%h want 0 0000",
                     cyc, host_rvalid, host_rdata);
        end
        advance();
        reset = 0;
        @(negedge clock); model_eval();
        checks++;
        if (obs_vec() !== e_vec || host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_model cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            cpu_req    = ($urandom_range(0, 3) != 0);
            cpu_we     = 1'($urandom);
            cpu_addr   = 8'($urandom);
            cpu_wdata  = 16'($urandom);
            host_req   = ($urandom_range(0, 1) != 0);
            host_we    = 1'($urandom);
            host_addr  = 8'($urandom);
            host_wdata = 16'($urandom);
            host_lock  = ($urandom_range(0, 3) != 0);
            @(negedge clock); model_eval();
            checks++;
            if (obs_vec() !== e_vec) begin
                errors++;
                $display("FAIL random cyc %0d got %h want %h", cyc, obs_vec(), e_vec);
            end
            advance();
        end
        reset = 0;
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1;
        @(posedge clock);
        model_commit();
        #1;
        test_reset();
        test_preload();
        test_cpu_write_read();
        test_starvation();
        test_lock_burst();
        test_interleaved_reads();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
